// File: rtl/log2_stream.sv
// rtl/log2_stream.sv - pipelined fixed-point log2 with valid/ready backpressure and channel tag
// Stages: leading-one detect, normalise, LUT fetch, interpolate; one global stall enable.
module log2_stream #(
    parameter int INPUT_WIDTH  = 18,
    parameter int INPUT_POINT  = 16,
    parameter int OUTPUT_POINT = 12,
    parameter int TABLE_WIDTH  = 4,
    parameter int CHANNELS     = 4,
    localparam int TW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int OWIDTH      = $clog2(INPUT_WIDTH) + OUTPUT_POINT + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] data_i,
    input  logic [TW-1:0]          chan_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [OWIDTH-1:0]      log2_o,
    output logic [TW-1:0]          chan_o,
    output logic                   zero_o,
    output logic                   valid_o,
    input  logic                   ready_i
);
    localparam int PW  = $clog2(INPUT_WIDTH);
    localparam int EW  = PW + 1;
    localparam int MW  = INPUT_WIDTH - 1;
    localparam int FW  = MW - TABLE_WIDTH;
    localparam int LW  = OUTPUT_POINT + 1;
    localparam int FRW = LW + 1;
    localparam int TS  = 2 ** TABLE_WIDTH;
    localparam int IXW = TABLE_WIDTH + 1;
    localparam int PRW = LW + FW + 1;
    localparam logic [PRW-1:0] ROUND_HALF = PRW'(2 ** (FW - 1));

    // Mantissa table: LUT[k] = round(log2(1 + k/2^TABLE_WIDTH) * 2^OUTPUT_POINT)
    logic [LW-1:0] lut [0:TS];
    for (genvar k = 0; k <= TS; k++) begin : g_lut
        localparam real LV = $ln(1.0 + real'(k) / real'(TS)) / $ln(2.0) * real'(2 ** OUTPUT_POINT);
        assign lut[k] = LW'($rtoi(LV + 0.5));
    end

    logic en;
    assign en      = ~valid_o | ready_i;
    assign ready_o = en;

    // Stage 1 registers
    logic                   s1_valid_q;
    logic [INPUT_WIDTH-1:0] s1_data_q;
    logic [TW-1:0]          s1_chan_q;
    logic                   s1_zero_q;
    logic [PW-1:0]          s1_lead_q;
    logic [PW-1:0]          s1_lead_d;
    logic                   s1_zero_d;

    // Stage 2 registers
    logic                   s2_valid_q;
    logic [MW-1:0]          s2_mant_q;
    logic signed [EW-1:0]   s2_exp_q;
    logic [TW-1:0]          s2_chan_q;
    logic                   s2_zero_q;
    logic [PW-1:0]          s2_shamt;
    logic [MW-1:0]          s2_mant_d;
    logic signed [EW-1:0]   s2_exp_d;

    // Stage 3 registers
    logic                   s3_valid_q;
    logic [LW-1:0]          s3_l0_q;
    logic [LW-1:0]          s3_d_q;
    logic [FW-1:0]          s3_f_q;
    logic signed [EW-1:0]   s3_exp_q;
    logic [TW-1:0]          s3_chan_q;
    logic                   s3_zero_q;
    logic [TABLE_WIDTH-1:0] s3_idx;
    logic [LW-1:0]          s3_l0_d;
    logic [LW-1:0]          s3_l1;
    logic [LW-1:0]          s3_d_d;
    logic [FW-1:0]          s3_f_d;

    // Output registers
    logic                   out_valid_q;
    logic [OWIDTH-1:0]      out_log_q;
    logic [TW-1:0]          out_chan_q;
    logic                   out_zero_q;
    logic [PRW-1:0]         s4_prod;
    logic [FRW-1:0]         s4_frac;
    logic [OWIDTH-1:0]      s4_log_d;

    always_comb begin
        s1_lead_d = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            if (data_i[i]) begin
                s1_lead_d = PW'(i);
            end
        end
        s1_zero_d = (data_i == '0);
    end

    // Shift the leading one to the MSB; the cast drops it, leaving the pure mantissa.
    always_comb begin
        s2_shamt  = PW'(INPUT_WIDTH - 1) - s1_lead_q;
        s2_mant_d = MW'(s1_data_q << s2_shamt);
        s2_exp_d  = EW'(s1_lead_q) - EW'(INPUT_POINT);
    end

    always_comb begin
        s3_idx  = s2_mant_q[MW-1 -: TABLE_WIDTH];
        s3_f_d  = s2_mant_q[FW-1:0];
        s3_l0_d = lut[{1'b0, s3_idx}];
        s3_l1   = lut[{1'b0, s3_idx} + IXW'(1)];
        s3_d_d  = s3_l1 - s3_l0_d;
    end

    always_comb begin
        s4_prod  = PRW'(s3_d_q) * PRW'(s3_f_q);
        s4_frac  = FRW'(s3_l0_q) + FRW'((s4_prod + ROUND_HALF) >> FW);
        s4_log_d = {s3_exp_q, {OUTPUT_POINT{1'b0}}} + OWIDTH'(s4_frac);
        if (s3_zero_q) begin
            s4_log_d = {1'b1, {(OWIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_chan_q   <= '0;
            s1_zero_q   <= 1'b0;
            s1_lead_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_mant_q   <= '0;
            s2_exp_q    <= '0;
            s2_chan_q   <= '0;
            s2_zero_q   <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_l0_q     <= '0;
            s3_d_q      <= '0;
            s3_f_q      <= '0;
            s3_exp_q    <= '0;
            s3_chan_q   <= '0;
            s3_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_log_q   <= '0;
            out_chan_q  <= '0;
            out_zero_q  <= 1'b0;
        end else if (en) begin
            // Bubbles advance as bubbles; payload registers only load behind a valid.
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_data_q <= data_i;
                s1_chan_q <= chan_i;
                s1_zero_q <= s1_zero_d;
                s1_lead_q <= s1_lead_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mant_q <= s2_mant_d;
                s2_exp_q  <= s2_exp_d;
                s2_chan_q <= s1_chan_q;
                s2_zero_q <= s1_zero_q;
            end
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_l0_q   <= s3_l0_d;
                s3_d_q    <= s3_d_d;
                s3_f_q    <= s3_f_d;
                s3_exp_q  <= s2_exp_q;
                s3_chan_q <= s2_chan_q;
                s3_zero_q <= s2_zero_q;
            end
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                out_log_q  <= s4_log_d;
                out_chan_q <= s3_chan_q;
                out_zero_q <= s3_zero_q;
            end
        end
    end

    assign valid_o = out_valid_q;
    assign log2_o  = out_log_q;
    assign chan_o  = out_chan_q;
    assign zero_o  = out_zero_q;

endmodule

// File: tb/tb_log2_stream.sv
// tb/tb_log2_stream.sv - directed vectors, stall/reset sequences and a strided sweep for log2_stream
module tb_log2_stream;
    localparam int IW = 18;
    localparam int TW = 2;
    localparam int OW = 18;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [IW-1:0]         data_i;
    logic [TW-1:0]         chan_i;
    logic                  valid_i;
    logic                  ready_o;
    logic signed [OW-1:0]  log2_o;
    logic [TW-1:0]         chan_o;
    logic                  zero_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  rdy_req;
    logic                  rand_rdy;
    logic                  rnd_bit = 1'b1;

    typedef struct {
        int  data;
        int  chan;
        real exp;
        real tol;
        bit  zero;
    } vec_t;

    typedef struct {
        int  chan;
        real exp;
        real tol;
        bit  zero;
        bit  lat;
        bit  consec;
        bit  mono;
        int  in_cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs [16];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_out_cyc = -100;
    int   prev_log = -1000000;
    bit   stalled_prev = 1'b0;
    logic signed [OW-1:0] snap_log;
    logic [TW-1:0]        snap_chan;
    logic                 snap_zero;

    log2_stream dut (
        .clock   (clock),
        .reset   (reset),
        .data_i  (data_i),
        .chan_i  (chan_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .log2_o  (log2_o),
        .chan_o  (chan_o),
        .zero_o  (zero_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end
    assign ready_i = rand_rdy ? rnd_bit : rdy_req;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk_exp(input vec_t v, input bit lat, input bit cs, input bit mo);
        exp_t e;
        e.chan = v.chan; e.exp = v.exp; e.tol = v.tol; e.zero = v.zero;
        e.lat = lat; e.consec = cs; e.mono = mo; e.in_cyc = cyc;
        return e;
    endfunction

    // Drive one sample until it transfers; called and returns at posedge+1.
    task automatic send(input vec_t v, input bit lat, input bit cs, input bit mo);
        int n = 0;
        data_i  = v.data[IW-1:0];
        chan_i  = v.chan[TW-1:0];
        valid_i = 1'b1;
        forever begin
            @(negedge clock);
            if (ready_o) break;
            n++;
            if (n > 500) begin
                chk("send_timeout", 1'b0, n, 500);
                valid_i = 1'b0;
                return;
            end
        end
        sb_q.push_back(mk_exp(v, lat, cs, mo));
        @(posedge clock);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 1'b0, sb_q.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t   e;
        int     act;
        real    diff;
        if (!reset && stalled_prev) begin
            chk("stall_stable", valid_o && log2_o == snap_log && chan_o == snap_chan && zero_o == snap_zero,
                log2_o, snap_log);
        end
        if (!reset && valid_o && ready_i) begin
            act = int'(log2_o);
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 1'b0, act, 0);
            end else begin
                e = sb_q.pop_front();
                diff = real'(act) - e.exp;
                chk("log2_value", diff <= e.tol && diff >= -e.tol, act, $rtoi(e.exp));
                chk("chan_tag", chan_o == e.chan[TW-1:0], chan_o, e.chan);
                chk("zero_flag", zero_o == e.zero, zero_o, e.zero);
                if (e.lat) chk("latency", cyc - e.in_cyc == 4, cyc - e.in_cyc, 4);
                if (e.consec) chk("back_to_back", cyc == last_out_cyc + 1, cyc - last_out_cyc, 1);
                if (e.mono) begin
                    chk("monotonic", act >= prev_log, act, prev_log);
                    prev_log = act;
                end
            end
            last_out_cyc = cyc;
        end
        stalled_prev = !reset && valid_o && !ready_i;
        snap_log  = log2_o;
        snap_chan = chan_o;
        snap_zero = zero_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   acc;
        vecs[0]  = '{1,      0, -65536.0,  0.0, 1'b0};
        vecs[1]  = '{2,      1, -61440.0,  0.0, 1'b0};
        vecs[2]  = '{4,      2, -57344.0,  0.0, 1'b0};
        vecs[3]  = '{256,    3, -32768.0,  0.0, 1'b0};
        vecs[4]  = '{4096,   0, -16384.0,  0.0, 1'b0};
        vecs[5]  = '{32768,  1, -4096.0,   0.0, 1'b0};
        vecs[6]  = '{131072, 2, 4096.0,    0.0, 1'b0};
        vecs[7]  = '{98304,  1, 2396.0,    4.0, 1'b0};
        vecs[8]  = '{0,      3, -131072.0, 0.0, 1'b1};
        vecs[9]  = '{196608, 0, 6492.0,    4.0, 1'b0};
        vecs[10] = '{3,      2, -59044.0,  4.0, 1'b0};
        vecs[11] = '{81920,  3, 1319.0,    4.0, 1'b0};
        vecs[12] = '{163840, 0, 5415.0,    4.0, 1'b0};
        vecs[13] = '{49152,  1, -1700.0,   4.0, 1'b0};
        vecs[14] = '{0,      0, -131072.0, 0.0, 1'b1};
        vecs[15] = '{100000, 2, 2497.0,    4.0, 1'b0};

        valid_i = 1'b0; data_i = '0; chan_i = '0;
        rdy_req = 1'b0; rand_rdy = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid_o", valid_o == 1'b0, valid_o, 0);
        chk("reset_log2_o", log2_o == 0, log2_o, 0);
        chk("reset_chan_o", chan_o == 0, chan_o, 0);
        chk("reset_zero_o", zero_o == 1'b0, zero_o, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", ready_o == 1'b1, ready_o, 1);
        rdy_req = 1'b1;
        @(posedge clock);
        #1;

        v = '{65536, 2, 0.0, 0.0, 1'b0};
        send(v, 1'b1, 1'b0, 1'b0);
        drain();

        send(vecs[0], 1'b1, 1'b0, 1'b0);
        v = '{131072, 1, 4096.0, 0.0, 1'b0};
        send(v, 1'b1, 1'b1, 1'b0);
        v = '{262143, 3, 8191.0, 4.0, 1'b0};
        send(v, 1'b1, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 16; i++) send(vecs[i], 1'b1, (i != 0), 1'b0);
        drain();

        // Downstream stalled while the source keeps offering samples
        rdy_req = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            data_i  = vecs[acc].data[IW-1:0];
            chan_i  = vecs[acc].chan[TW-1:0];
            valid_i = 1'b1;
            @(negedge clock);
            if (ready_o) begin
                sb_q.push_back(mk_exp(vecs[acc], 1'b0, 1'b0, 1'b0));
                acc++;
            end
            @(posedge clock);
            #1;
        end
        chk("stall_accept_count", acc == 4, acc, 4);
        chk("stall_ready_low", ready_o == 1'b0, ready_o, 0);
        chk("stall_valid_high", valid_o == 1'b1, valid_o, 1);
        valid_i = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 4; i < 16; i++) send(vecs[i], 1'b0, 1'b0, 1'b0);
        drain();
        rand_rdy = 1'b0;
        rdy_req = 1'b1;
        @(posedge clock);
        #1;

        // Three samples in flight, then a one-cycle reset discards them
        data_i = 18'd65536; chan_i = 2'd1; valid_i = 1'b1;
        @(posedge clock); #1;
        data_i = 18'd131072; chan_i = 2'd2;
        @(posedge clock); #1;
        data_i = 18'd4; chan_i = 2'd3;
        @(posedge clock); #1;
        valid_i = 1'b0;
        rdy_req = 1'b0;
        @(posedge clock); #1;
        chk("inflight_visible", valid_o == 1'b1, valid_o, 1);
        reset = 1'b1;
        #1;
        chk("reset_drops_valid", valid_o == 1'b0, valid_o, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        rdy_req = 1'b1;
        v = '{196608, 2, 6492.0, 4.0, 1'b0};
        send(v, 1'b1, 1'b0, 1'b0);
        drain();

        for (int x = 1; x < (1 << IW); x += 7) begin
            v.data = x;
            v.chan = x % 4;
            v.exp  = $ln(real'(x) / 65536.0) / $ln(2.0) * 4096.0;
            v.tol  = 4.0;
            v.zero = 1'b0;
            send(v, 1'b0, 1'b0, 1'b1);
        end
        drain();

        chk("scoreboard_empty", sb_q.size() == 0, sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/log2_stream.md
Name: log2_stream

Overview:
- Pipelined fixed-point log2 unit with valid/ready backpressure and a per-sample channel tag.
- Uses leading-one normalisation and a linearly interpolated mantissa LUT.
- Flags a zero input explicitly instead of producing garbage.
- Next-generation replacement for the free-running log2cordic/log2lut/log2lin units. It sits between multi-channel sample streams and downstream dB/level logic that can stall.

Parameters:
- INPUT_WIDTH, 18, unsigned input width.
- INPUT_POINT, 16, input fractional bits.
- OUTPUT_POINT, 12, output fractional bits.
- TABLE_WIDTH, 4, mantissa MSBs indexing the LUT; the LUT has 2^TABLE_WIDTH+1 entries.
- CHANNELS, 4, number of tag values; TW = max(1, $clog2(CHANNELS)).
- OWIDTH (localparam), $clog2(INPUT_WIDTH)+OUTPUT_POINT+1, signed output width.

Ports:
- clock  in  1  system clock, all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_i  in  INPUT_WIDTH  unsigned input sample.
- chan_i  in  TW  channel tag of the input sample.
- valid_i  in  1  input sample valid.
- ready_o  out  1  unit accepts an input this cycle.
- log2_o  out  OWIDTH  signed log2(data_i/2^INPUT_POINT), OUTPUT_POINT fractional bits.
- chan_o  out  TW  tag travelling with the result.
- zero_o  out  1  input was zero; log2_o is saturated.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.

Behaviour:
- Reset (async assert, sync release):
  - Every pipeline valid bit clears.
  - valid_o=0, log2_o=0, chan_o=0, zero_o=0.
  - ready_o=1 once reset is deasserted.
- Handshake:
  - Global enable en = ~valid_o | ready_i; ready_o = en (combinational from ready_i).
  - An input transfers when valid_i & ready_o; an output transfers when valid_o & ready_i.
  - When en=0 every stage holds, and log2_o/chan_o/zero_o/valid_o stay stable.
  - Empty stages (bubbles) are not collapsed. Samples are never dropped or reordered.
- Latency: exactly 4 enabled cycles from input transfer to valid_o. Throughput is 1 sample/cycle while ready_i=1.
- Stages:
  - S1: register data, tag and zero flag. p = index of the leading one, 0..INPUT_WIDTH-1 (priority encoder).
  - S2: mantissa m = data << (INPUT_WIDTH-1-p), with the leading one dropped. Register the exponent e = p - INPUT_POINT (signed).
  - S3: idx = top TABLE_WIDTH bits of m; f = the remaining bits. Look up L0=LUT[idx] and L1=LUT[idx+1], where LUT[k] = round(log2(1+k/2^TABLE_WIDTH) * 2^OUTPUT_POINT). LUT[0]=0 and LUT[2^TABLE_WIDTH]=2^OUTPUT_POINT, elaborated from real math at build time. Register L0, D=L1-L0, f.
  - S4: frac = L0 + ((D*f + half-LSB) >> width(f)), rounded. Then log2_o = (e << OUTPUT_POINT) + frac.
- Zero input: zero_o=1 and log2_o = -2^(OWIDTH-1) (most negative value); the tag still passes through.
- Accuracy (nonzero input, defaults): |log2_o/2^OUTPUT_POINT - log2(x)| <= 4 LSB.
  - Exact powers of two give an exact result (frac=0).
  - log2_o is monotonic non-decreasing in data_i.
- Width rules:
  - Shifts and products use full internal width; truncation happens only at the final rounding.
  - Max output (INPUT_WIDTH-INPUT_POINT)*2^OUTPUT_POINT minus a fraction always fits in OWIDTH.
- Simultaneous input and output transfer in the same cycle: both happen, with no extra bubble.
- Reset mid-stream: all in-flight samples are discarded. The next sample accepted after reset is the next output.

Test Plan:
- data_i=65536 (1.0), chan 2 -> after 4 cycles valid_o=1, log2_o=0, chan_o=2, zero_o=0.
- data_i=1, then 131072, then 262143, back-to-back -> log2_o = -65536, 4096, and 8191±4, on consecutive cycles.
- data_i=98304 (1.5) -> log2_o = 2396±4. Sweep all 2^18 inputs: error <=4 LSB, monotonic, exact at powers of two.
- data_i=0, chan 3 -> zero_o=1, log2_o=-131072, chan_o=3. The next nonzero sample is unaffected.
- Hold ready_i=0 with valid_i=1 for 10 cycles:
  - The unit accepts samples until the first reaches the output, then ready_o=0.
  - Outputs stay stable while stalled.
  - Release with random ready_i toggling -> all samples out in order with correct tags, none lost or duplicated.
- Assert reset for one cycle with 3 samples in flight -> valid_o drops immediately and none of the 3 appear. The next input produces output 4 cycles after its transfer.
